// File: rtl/dragonfang_floating_point_pkg.sv
// rtl/dragonfang_floating_point_pkg.sv - shared types for the floating-point comparison and mask packing path
//
// Contents:
//   MASK_WORD_WIDTH   width of one vector mask register write word
//   MASK_INDEX_WIDTH  width of a bit position inside a word, able to hold MASK_WORD_WIDTH itself
//   bit_mode_t        element width selector shared with the comparison unit (2'b11 is not a legal mode)
//   packer_state_t    mask packer control states
//   is_legal_bit_mode helper that rejects unsupported bit_mode encodings
package dragonfang_floating_point_pkg;

    localparam int MASK_WORD_WIDTH  = 64;
    localparam int MASK_INDEX_WIDTH = $clog2(MASK_WORD_WIDTH + 1);

    typedef enum logic [1:0] {
        BIT_MODE_DISABLED  = 2'b00,
        ENABLED_32BIT_MODE = 2'b01,
        ENABLED_64BIT_MODE = 2'b10
    } bit_mode_t;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        ACCUMULATE = 2'b01,
        EMIT       = 2'b10
    } packer_state_t;

    function automatic logic is_legal_bit_mode(input bit_mode_t mode);
        return (mode == ENABLED_32BIT_MODE) || (mode == ENABLED_64BIT_MODE);
    endfunction

endpackage

// File: rtl/vector_mask_packing_unit.sv
// rtl/vector_mask_packing_unit.sv - packs per-element compare results into 64-bit vector mask words
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start, vector_length,   begin one instruction (sampled in IDLE only); length and mode are latched
//   bit_mode
//   result_valid/_ready,    compare result beats; bit0 (64-bit mode) or bits[1:0] (32-bit mode) are used
//   result
//   mask_valid/_ready,      packed mask words, bit i = element 64*word+i; mask_last marks the final word
//   mask, mask_last
//   busy                    high whenever an instruction is in flight
//   done                    one-cycle completion pulse
//   active_count            number of set mask bits of the last instruction
//                           (present only when VECTOR_MASK_POPCOUNT_EN is defined)
module vector_mask_packing_unit
    import dragonfang_floating_point_pkg::*;
#(
    parameter int MAX_VL   = 256,
    parameter int VL_WIDTH = $clog2(MAX_VL + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [VL_WIDTH-1:0]        vector_length,
    input  bit_mode_t                  bit_mode,
    input  logic                       result_valid,
    output logic                       result_ready,
    input  logic [MASK_WORD_WIDTH-1:0] result,
    output logic                       mask_valid,
    input  logic                       mask_ready,
    output logic [MASK_WORD_WIDTH-1:0] mask,
    output logic                       mask_last,
    output logic                       busy,
    output logic                       done
`ifdef VECTOR_MASK_POPCOUNT_EN
    ,
    output logic [VL_WIDTH-1:0]        active_count
`endif
);

    packer_state_t               state_q, state_d;
    logic [MASK_WORD_WIDTH-1:0]  word_q, word_d;
    logic [MASK_INDEX_WIDTH-1:0] bit_index_q, bit_index_d;
    logic [VL_WIDTH-1:0]         elements_left_q, elements_left_d;
    bit_mode_t                   mode_q, mode_d;
    logic                        last_q, last_d;
    logic                        done_q, done_d;
`ifdef VECTOR_MASK_POPCOUNT_EN
    logic [VL_WIDTH-1:0]         count_q, count_d;
`endif

    logic                        start_ok;
    logic                        beat_fire;
    logic [1:0]                  beat_k;
    logic [1:0]                  beat_bits;
    logic [MASK_INDEX_WIDTH-1:0] bit_index_inc;
    logic [VL_WIDTH-1:0]         elements_left_dec;
    logic                        word_full;
    logic                        elems_done;

    // Only the low two bits of the compare result carry element data.
    logic unused_result_bits;
    assign unused_result_bits = ^result[MASK_WORD_WIDTH-1:2];

    // ORs k result bits into the word at idx; positions at and above idx are
    // always clear because the word is zeroed before each fill.
    function automatic logic [MASK_WORD_WIDTH-1:0] insert_bits(
        input logic [MASK_WORD_WIDTH-1:0]  word,
        input logic [MASK_INDEX_WIDTH-1:0] idx,
        input logic [1:0]                  bits,
        input logic [1:0]                  k
    );
        logic [MASK_WORD_WIDTH-1:0] field;
        field = {{(MASK_WORD_WIDTH-2){1'b0}}, bits & ((k == 2'd2) ? 2'b11 : 2'b01)};
        return word | (field << idx);
    endfunction

    assign start_ok  = start && is_legal_bit_mode(bit_mode) && (vector_length != '0);
    assign beat_fire = (state_q == ACCUMULATE) && result_valid;

    // A lone trailing element in 32-bit mode consumes only bit0 of its beat.
    assign beat_k    = ((mode_q == ENABLED_32BIT_MODE) && (elements_left_q != VL_WIDTH'(1))) ? 2'd2 : 2'd1;
    assign beat_bits = {(beat_k == 2'd2) & result[1], result[0]};

    assign bit_index_inc     = bit_index_q + MASK_INDEX_WIDTH'(beat_k);
    assign elements_left_dec = elements_left_q - VL_WIDTH'(beat_k);
    assign word_full         = (bit_index_inc == MASK_INDEX_WIDTH'(MASK_WORD_WIDTH));
    assign elems_done        = (elements_left_dec == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            word_q          <= '0;
            bit_index_q     <= '0;
            elements_left_q <= '0;
            mode_q          <= BIT_MODE_DISABLED;
            last_q          <= 1'b0;
            done_q          <= 1'b0;
`ifdef VECTOR_MASK_POPCOUNT_EN
            count_q         <= '0;
`endif
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            bit_index_q     <= bit_index_d;
            elements_left_q <= elements_left_d;
            mode_q          <= mode_d;
            last_q          <= last_d;
            done_q          <= done_d;
`ifdef VECTOR_MASK_POPCOUNT_EN
            count_q         <= count_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = ACCUMULATE;
                end
            end
            ACCUMULATE: begin
                if (beat_fire && (word_full || elems_done)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (mask_ready) begin
                    state_d = last_q ? IDLE : ACCUMULATE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_d          = word_q;
        bit_index_d     = bit_index_q;
        elements_left_d = elements_left_q;
        mode_d          = mode_q;
        last_d          = last_q;
        done_d          = 1'b0;
`ifdef VECTOR_MASK_POPCOUNT_EN
        count_d         = count_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef VECTOR_MASK_POPCOUNT_EN
                    count_d = '0;
`endif
                    if (start_ok) begin
                        mode_d          = bit_mode;
                        elements_left_d = vector_length;
                        word_d          = '0;
                        bit_index_d     = '0;
                        last_d          = 1'b0;
                    end else begin
                        // Empty or unsupported request completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            ACCUMULATE: begin
                if (beat_fire) begin
                    word_d          = insert_bits(word_q, bit_index_q, beat_bits, beat_k);
                    bit_index_d     = bit_index_inc;
                    elements_left_d = elements_left_dec;
                    last_d          = elems_done;
`ifdef VECTOR_MASK_POPCOUNT_EN
                    count_d         = count_q + VL_WIDTH'(beat_bits[0]) + VL_WIDTH'(beat_bits[1]);
`endif
                end
            end
            EMIT: begin
                if (mask_ready) begin
                    if (last_q) begin
                        done_d = 1'b1;
                    end else begin
                        word_d      = '0;
                        bit_index_d = '0;
                    end
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        result_ready = (state_q == ACCUMULATE);
        mask_valid   = (state_q == EMIT);
        mask         = (state_q == EMIT) ? word_q : '0;
        mask_last    = (state_q == EMIT) && last_q;
        busy         = (state_q != IDLE);
        done         = done_q;
    end

`ifdef VECTOR_MASK_POPCOUNT_EN
    assign active_count = count_q;
`endif

endmodule

// File: tb/tb_vector_mask_packing_unit.sv
// tb/tb_vector_mask_packing_unit.sv - scoreboard bench for vector_mask_packing_unit (honours VECTOR_MASK_POPCOUNT_EN)
module tb_vector_mask_packing_unit;
    import dragonfang_floating_point_pkg::*;

    localparam int MAX_VL = 256;
    localparam int VLW    = $clog2(MAX_VL + 1);

    typedef struct packed {
        logic [63:0] m;
        logic        l;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [VLW-1:0]  vector_length = '0;
    bit_mode_t       bit_mode = ENABLED_64BIT_MODE;
    logic            result_valid = 1'b0;
    logic            result_ready;
    logic [63:0]     result = '0;
    logic            mask_valid;
    logic            mask_ready = 1'b0;
    logic [63:0]     mask;
    logic            mask_last;
    logic            busy;
    logic            done;
`ifdef VECTOR_MASK_POPCOUNT_EN
    logic [VLW-1:0]  active_count;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   last_hs_cyc = 0;
    bit   hold_low = 1'b0;
    bit   pending_last = 1'b0;
    bit   prev_stall = 1'b0;
    logic [63:0] prev_mask = '0;
    logic        prev_last = 1'b0;
    exp_t sb_q[$];

    vector_mask_packing_unit #(.MAX_VL(MAX_VL)) dut (
        .clock(clock), .reset(reset), .start(start),
        .vector_length(vector_length), .bit_mode(bit_mode),
        .result_valid(result_valid), .result_ready(result_ready), .result(result),
        .mask_valid(mask_valid), .mask_ready(mask_ready), .mask(mask), .mask_last(mask_last),
        .busy(busy), .done(done)
`ifdef VECTOR_MASK_POPCOUNT_EN
        , .active_count(active_count)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream consumer: random acceptance unless a stall is requested.
    initial forever begin
        @(posedge clock);
        #2;
        mask_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every emitted word against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", mask_valid, 1);
                check_eq("hold_mask", mask, prev_mask);
                check_eq("hold_last", mask_last, prev_last);
            end
            if (mask_valid) check_eq("no_ready_in_emit", result_ready, 0);
            if (mask_valid && mask_ready) begin
                check_eq("word_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_eq("mask", mask, e.m);
                    check_eq("mask_last", mask_last, e.l);
                    if (mask_last) begin
                        pending_last = 1'b1;
                        last_hs_cyc  = cyc;
                    end
                end
            end
            prev_stall = mask_valid && !mask_ready;
            prev_mask  = mask;
            prev_last  = mask_last;
            if (done) begin
                done_cnt++;
                if (pending_last) begin
                    check_eq("done_latency", cyc, last_hs_cyc + 1);
                    pending_last = 1'b0;
                end
            end
        end
    end

    // Reference model: word w bit i is element 64*w+i; the last word is the one reaching vl.
    task automatic run_instr(input bit_mode_t mode, input int vl, input logic el[$],
                             input bit spurious, input bit stall);
        int   nbeats, b, guard, pop;
        bit   acc, spur_done;
        exp_t e;
        pop = 0;
        for (int i = 0; i < vl; i++) pop += el[i];
        for (int w = 0; w * 64 < vl; w++) begin
            e.m = '0;
            for (int i = 0; i < 64 && w * 64 + i < vl; i++) e.m[i] = el[w * 64 + i];
            e.l = ((w + 1) * 64 >= vl);
            sb_q.push_back(e);
        end
        exp_done++;
        hold_low = stall;
        @(posedge clock); #1;
        start = 1'b1; vector_length = VLW'(vl); bit_mode = mode;
        @(posedge clock); #1;
        start = 1'b0;
        nbeats = (mode == ENABLED_32BIT_MODE) ? (vl + 1) / 2 : vl;
        b = 0; guard = 0; spur_done = 1'b0;
        while (b < nbeats && guard < 4000) begin
            if (spurious && !spur_done && b >= nbeats / 2) begin
                start = 1'b1;
                vector_length = VLW'($urandom_range(1, MAX_VL));
                bit_mode = (mode == ENABLED_32BIT_MODE) ? ENABLED_64BIT_MODE : ENABLED_32BIT_MODE;
                spur_done = 1'b1;
            end
            result_valid = ($urandom_range(0, 3) != 0);
            result = {$urandom(), $urandom()};
            if (mode == ENABLED_32BIT_MODE) begin
                result[0] = el[2 * b];
                if (2 * b + 1 < vl) result[1] = el[2 * b + 1];
            end else begin
                result[0] = el[b];
            end
            @(negedge clock);
            acc = result_valid && result_ready;
            @(posedge clock); #1;
            start = 1'b0;
            if (acc) b++;
            guard++;
        end
        result_valid = 1'b0;
        check_eq("beats_accepted", b, nbeats);
        @(negedge clock);
        check_eq("ready_after_last", result_ready, 0);
        if (stall) begin
            repeat (10) @(posedge clock);
            #1;
            hold_low = 1'b0;
        end
        guard = 0;
        while (done_cnt < exp_done && guard < 4000) begin
            @(posedge clock);
            guard++;
        end
        @(negedge clock);
        check_eq("done_count", done_cnt, exp_done);
        check_eq("sb_drained", sb_q.size(), 0);
        check_eq("idle_after_done", busy, 0);
`ifdef VECTOR_MASK_POPCOUNT_EN
        check_eq("active_count", active_count, pop);
`endif
    endtask

    task automatic quick_start(input bit_mode_t mode, input int vl, input string name);
        @(posedge clock); #1;
        start = 1'b1; vector_length = VLW'(vl); bit_mode = mode;
        @(posedge clock); #1;
        start = 1'b0;
        exp_done++;
        @(negedge clock);
        check_eq({name, "_done"}, done, 1);
        check_eq({name, "_busy"}, busy, 0);
        check_eq({name, "_valid"}, mask_valid, 0);
`ifdef VECTOR_MASK_POPCOUNT_EN
        check_eq({name, "_count"}, active_count, 0);
`endif
        @(negedge clock);
        check_eq({name, "_pulse"}, done, 0);
    endtask

    initial begin
        logic el[$];
        int   vl;
        bit_mode_t mode;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", mask_valid, 0);
        check_eq("rst_ready", result_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_mask", mask, 0);
        check_eq("rst_last", mask_last, 0);
        reset = 1'b0;

        el = '{1'b1, 1'b0, 1'b1};
        run_instr(ENABLED_64BIT_MODE, 3, el, 1'b0, 1'b0);

        el = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        run_instr(ENABLED_32BIT_MODE, 5, el, 1'b0, 1'b0);

        el = {};
        for (int i = 0; i < 128; i++) el.push_back(i % 2);
        run_instr(ENABLED_32BIT_MODE, 128, el, 1'b1, 1'b0);

        el = {};
        for (int i = 0; i < 64; i++) el.push_back($urandom_range(0, 1));
        run_instr(ENABLED_64BIT_MODE, 64, el, 1'b0, 1'b1);

        quick_start(ENABLED_64BIT_MODE, 0, "zero_vl");
        quick_start(bit_mode_t'(2'b11), 10, "bad_mode");

        // Reset 20 beats into a 64-element instruction: no word, no done.
        @(posedge clock); #1;
        start = 1'b1; vector_length = VLW'(64); bit_mode = ENABLED_64BIT_MODE;
        @(posedge clock); #1;
        start = 1'b0; result_valid = 1'b1; result = '1;
        repeat (20) @(posedge clock);
        #1;
        result_valid = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_valid", mask_valid, 0);
        check_eq("midrst_ready", result_ready, 0);
        check_eq("midrst_mask", mask, 0);
        check_eq("midrst_done", done, 0);
`ifdef VECTOR_MASK_POPCOUNT_EN
        check_eq("midrst_count", active_count, 0);
`endif
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_eq("midrst_no_done", done_cnt, exp_done);

        for (int t = 0; t < 25; t++) begin
            mode = ($urandom_range(0, 1) != 0) ? ENABLED_32BIT_MODE : ENABLED_64BIT_MODE;
            case ($urandom_range(0, 4))
                0: vl = 64 * $urandom_range(1, MAX_VL / 64);
                1: vl = 1;
                default: vl = $urandom_range(1, MAX_VL);
            endcase
            el = {};
            for (int i = 0; i < vl; i++) el.push_back($urandom_range(0, 1));
            run_instr(mode, vl, el, ($urandom_range(0, 2) == 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
